// File: rtl/program_run_sequencer_pkg.sv
// Shared types and defaults for the program run sequencer.
package program_run_sequencer_pkg;

  localparam int unsigned WordW          = 64;
  localparam int unsigned DefResetCycles = 2;
  localparam int unsigned DefWdogLimit   = 255;

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StRun,
    StCheck,
    StDone
  } state_e;

endpackage

// File: rtl/run_watchdog.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
module run_watchdog #(
  parameter int unsigned Width     = 8,
  parameter int unsigned TermCount = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [Width-1:0] TermVal = Width'(TermCount);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TermVal)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TermVal);

endmodule

// File: rtl/program_run_sequencer.sv
// Run controller: holds the core in reset, runs it to an end PC or watchdog, then scores the result.
module program_run_sequencer
  import program_run_sequencer_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DefResetCycles,
  parameter int unsigned WDOG_LIMIT   = DefWdogLimit,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             start,
  input  logic [WordW-1:0] cfg_startpc,
  input  logic [WordW-1:0] cfg_endpc,
  input  logic [WordW-1:0] cfg_expected,
  input  logic [WordW-1:0] currentpc,
  input  logic [WordW-1:0] MemtoRegOut,
  output logic             proc_resetl,
  output logic [WordW-1:0] startpc,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [WordW-1:0] captured,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] pass_count
);

  localparam int unsigned RstW  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned WdogW = $clog2(WDOG_LIMIT + 1);

  state_e           state_d, state_q;
  logic [WordW-1:0] startpc_d, startpc_q, endpc_d, endpc_q, expected_d, expected_q;
  logic [WordW-1:0] captured_d, captured_q;
  logic             proc_resetl_d, proc_resetl_q;
  logic             pass_d, pass_q, timeout_d, timeout_q;
  logic [CNT_W-1:0] run_count_d, run_count_q, pass_count_d, pass_count_q;
  logic             accept, rst_tc, wdog_tc;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  run_watchdog #(
    .Width     (RstW),
    .TermCount (RESET_CYCLES - 1)
  ) u_rst_hold (
    .clk_i  (CLK),
    .rst_ni (resetl),
    .clr_i  (accept),
    .en_i   (state_q == StReset),
    .tc_o   (rst_tc)
  );

  // Held clear through RESET so the first RUN cycle sees a count of zero.
  run_watchdog #(
    .Width     (WdogW),
    .TermCount (WDOG_LIMIT - 1)
  ) u_wdog (
    .clk_i  (CLK),
    .rst_ni (resetl),
    .clr_i  (state_q == StReset),
    .en_i   (state_q == StRun),
    .tc_o   (wdog_tc)
  );

  always_comb begin
    state_d      = state_q;
    startpc_d    = startpc_q;
    endpc_d      = endpc_q;
    expected_d   = expected_q;
    captured_d   = captured_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    run_count_d  = run_count_q;
    pass_count_d = pass_count_q;

    if (accept) begin
      startpc_d  = cfg_startpc;
      endpc_d    = cfg_endpc;
      expected_d = cfg_expected;
      pass_d     = 1'b0;
      timeout_d  = 1'b0;
    end

    unique case (state_q)
      StIdle:  if (start) state_d = StReset;
      StReset: if (rst_tc) state_d = StRun;
      StRun: begin
        // End address beats the watchdog when both hit together.
        if (currentpc >= endpc_q) begin
          state_d = StCheck;
        end else if (wdog_tc) begin
          timeout_d = 1'b1;
          state_d   = StCheck;
        end
      end
      StCheck: begin
        captured_d  = MemtoRegOut;
        pass_d      = (MemtoRegOut == expected_q) && !timeout_q;
        run_count_d = run_count_q + CNT_W'(1);
        if (pass_d) pass_count_d = pass_count_q + CNT_W'(1);
        state_d = StDone;
      end
      StDone:  if (start) state_d = StReset;
      default: state_d = StIdle;
    endcase

    proc_resetl_d = (state_d == StRun) || (state_d == StCheck) || (state_d == StDone);
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q       <= StIdle;
      startpc_q     <= '0;
      endpc_q       <= '0;
      expected_q    <= '0;
      captured_q    <= '0;
      proc_resetl_q <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      run_count_q   <= '0;
      pass_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      startpc_q     <= startpc_d;
      endpc_q       <= endpc_d;
      expected_q    <= expected_d;
      captured_q    <= captured_d;
      proc_resetl_q <= proc_resetl_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      run_count_q   <= run_count_d;
      pass_count_q  <= pass_count_d;
    end
  end

  assign proc_resetl = proc_resetl_q;
  assign startpc     = startpc_q;
  assign busy        = (state_q == StReset) || (state_q == StRun) || (state_q == StCheck);
  assign done        = (state_q == StDone);
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign captured    = captured_q;
  assign run_count   = run_count_q;
  assign pass_count  = pass_count_q;

endmodule
